// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit Kogge-Stone adder among NREQ requesters, with a
// single registered result slot. Define ADDER_ARB_SUB_EN to enable per-request subtraction.

module koggestone64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] p0;
  logic [63:0] g_final;

  assign p0 = a ^ b;

  genvar gl;
  generate
    for (gl = 0; gl <= 6; gl++) begin : lvl
      logic [63:0] g;
      logic [63:0] p;
      if (gl == 0) begin : g_init
        // Carry-in is folded into bit 0's generate so prefix outputs are true carries.
        assign g = (a & b) | {63'd0, p0[0] & cin};
        assign p = p0;
      end else begin : g_step
        localparam int D = 1 << (gl - 1);
        localparam logic [63:0] LOW_MASK = (64'd1 << D) - 64'd1;
        assign g = lvl[gl-1].g | (lvl[gl-1].p & (lvl[gl-1].g << D));
        assign p = lvl[gl-1].p & ((lvl[gl-1].p << D) | LOW_MASK);
      end
    end
  endgenerate

  assign g_final = lvl[6].g;
  assign sum     = p0 ^ {g_final[62:0], cin};
  assign cout    = g_final[63];

endmodule

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_sum,
  output logic                 res_cout,
  output logic [IDW-1:0]       res_id
);

  localparam int NPAD = 2 ** IDW;
  localparam logic [IDW:0]   NREQ_W = NREQ[IDW:0];
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [63:0]    sum_q, sum_d;
  logic           cout_q, cout_d;
  logic [IDW-1:0] id_q, id_d;

  logic [NPAD-1:0] valid_pad;
  logic [IDW:0]    idx;
  logic [IDW-1:0]  win;
  logic            any_valid;
  logic            slot_free;
  logic            accept;

  logic [63:0] sel_a, sel_b;
  logic        sel_cin, sel_sub;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;
  logic        add_cout;

  assign valid_pad = NPAD'(req_valid);

  // Scan offsets from the far end so the requester closest to ptr is the last to assign win.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + k[IDW:0];
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (valid_pad[idx[IDW-1:0]]) begin
        win       = idx[IDW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign slot_free = (state_q == EMPTY) | res_ready;
  assign accept    = any_valid & slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept & (win == IDW'(gi));
    end
  endgenerate

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a   = req_a[64*i +: 64];
        sel_b   = req_b[64*i +: 64];
        sel_cin = req_cin[i];
        sel_sub = req_sub[i];
      end
    end
  end

`ifdef ADDER_ARB_SUB_EN
  // a - b as a + ~b + 1; the requester's carry-in is ignored when subtracting.
  assign add_b   = sel_sub ? ~sel_b : sel_b;
  assign add_cin = sel_sub | sel_cin;
`else
  logic unused_sub;
  assign unused_sub = sel_sub;
  assign add_b      = sel_b;
  assign add_cin    = sel_cin;
`endif

  koggestone64bit u_adder (
    .a    (sel_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    if (accept) begin
      state_d = FULL;
      sum_d   = add_sum;
      cout_d  = add_cout;
      id_d    = win;
      ptr_d   = (win == LAST_ID) ? '0 : win + 1'b1;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a cycle model of the arbitration/result-slot rules is checked every
// negedge, while directed vectors pin literal expected sums, ids and handshake timing.

module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADDER_ARB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*64-1:0]   req_a;
  logic [NREQ*64-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic [NREQ-1:0]      req_sub;
  logic                 res_valid;
  logic                 res_ready;
  logic [63:0]          res_sum;
  logic                 res_cout;
  logic [IDW-1:0]       res_id;

  int total = 0;
  int bad   = 0;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state as it should be after the most recent rising edge.
  bit          m_valid = 1'b0;
  logic [63:0] m_sum   = '0;
  logic        m_cout  = 1'b0;
  int          m_id    = 0;
  int          m_ptr   = 0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] e_ready;
    logic [64:0]     full;
    logic [63:0]     a, b;
    int              w, i;
    if (!reset_n) begin
      check("rst_valid", res_valid, 0);
      check("rst_sum", res_sum, 0);
      check("rst_cout", res_cout, 0);
      check("rst_id", res_id, 0);
      m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0; m_ptr = 0;
    end else begin
      check("m_valid", res_valid, m_valid);
      check("m_sum", res_sum, m_sum);
      check("m_cout", res_cout, m_cout);
      check("m_id", res_id, m_id);
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[i]) w = i;
      end
      e_ready = '0;
      if (w >= 0 && (!m_valid || res_ready)) e_ready[w] = 1'b1;
      check("m_ready", req_ready, e_ready);
      if (e_ready != '0) begin
        a = req_a[64*w +: 64];
        b = req_b[64*w +: 64];
        if (SUB_EN && req_sub[w]) full = {1'b0, a} + {1'b0, ~b} + 65'd1;
        else                      full = {1'b0, a} + {1'b0, b} + {64'd0, req_cin[w]};
        m_sum = full[63:0]; m_cout = full[64]; m_id = w; m_valid = 1'b1;
        m_ptr = (w + 1) % NREQ;
        $display("xfer id=%0d a=%h b=%h cin=%b sub=%b sum=%h cout=%b",
                 w, a, b, req_cin[w], req_sub[w], m_sum, m_cout);
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic do_single(input string name, input int i, input logic [63:0] a,
                           input logic [63:0] b, input logic cin, input logic sub,
                           input logic [63:0] exp_sum, input logic exp_cout);
    logic [NREQ-1:0] one;
    one = '0;
    one[i] = 1'b1;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_cin[i] = cin;
    req_sub[i] = sub;
    req_valid = one;
    #1;
    check({name, "_rdy"}, req_ready, one);
    tick();
    req_valid = '0;
    check({name, "_valid"}, res_valid, 1);
    check({name, "_sum"}, res_sum, exp_sum);
    check({name, "_cout"}, res_cout, exp_cout);
    check({name, "_id"}, res_id, i);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    res_ready = 1'b1;
    #3;
    check("init_valid", res_valid, 0);
    check("init_id", res_id, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Single request, one-cycle latency.
    do_single("single", 0, 64'd20, 64'd20, 1'b0, 1'b0, 64'd40, 1'b0);
    tick();
    check("drain_valid", res_valid, 0);
    check("drain_sum_hold", res_sum, 40);

    // All four requesters valid from reset: order 0,1,2,3,0.
    reset_pulse();
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64] = 64'(i);
      req_b[64*i +: 64] = 64'd100;
      req_cin[i] = 1'b0;
    end
    req_valid = '1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr_id%0d", j), res_id, j % NREQ);
      check($sformatf("rr_sum%0d", j), res_sum, 100 + (j % NREQ));
      check($sformatf("rr_valid%0d", j), res_valid, 1);
    end

    // Backpressure with req1 pending.
    req_valid = 4'b0010;
    res_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_ready", req_ready, 0);
      tick();
      check("bp_sum", res_sum, 100);
      check("bp_id", res_id, 0);
      check("bp_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_rdy", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("bp_after_sum", res_sum, 101);
    check("bp_after_id", res_id, 1);
    check("bp_after_valid", res_valid, 1);
    tick();

    // Carry boundaries.
    do_single("carry_wrap", 3, 64'hffff_ffff_ffff_ffff, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    do_single("carry_all", 2, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0,
              64'hffff_ffff_ffff_ffff, 1'b1);
    do_single("carry_mid", 0, 64'hefff_ffff_ffff_ffff, 64'h0f0f_0f0f_0f0f_0f0f, 1'b1, 1'b0,
              64'hff0f_0f0f_0f0f_0f0f, 1'b0);

    // Reset mid-operation with ptr=2 and a held result.
    do_single("pre_rst", 1, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0);
    res_ready = 1'b0;
    req_a[64*0 +: 64] = 64'd11; req_b[64*0 +: 64] = 64'd1; req_cin[0] = 1'b0; req_sub[0] = 1'b0;
    req_a[64*2 +: 64] = 64'd22; req_b[64*2 +: 64] = 64'd2; req_cin[2] = 1'b0; req_sub[2] = 1'b0;
    req_valid = 4'b0101;
    #1;
    check("pre_rst_rdy", req_ready, 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", res_valid, 0);
    tick();
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    #1;
    check("post_rst_rdy", req_ready, 4'b0001);
    tick();
    check("post_rst_id0", res_id, 0);
    check("post_rst_sum0", res_sum, 12);
    tick();
    req_valid = '0;
    check("post_rst_id2", res_id, 2);
    check("post_rst_sum2", res_sum, 24);
    tick();

`ifdef ADDER_ARB_SUB_EN
    do_single("sub_neg", 1, 64'd5000, 64'd5001, 1'b0, 1'b1, 64'hffff_ffff_ffff_ffff, 1'b0);
    do_single("sub_pos", 1, 64'd540, 64'd480, 1'b1, 1'b1, 64'd60, 1'b1);
`else
    do_single("sub_ignored", 1, 64'd7, 64'd3, 1'b0, 1'b1, 64'd10, 1'b0);
`endif
    tick();
    check("final_valid", res_valid, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
